// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, N data bits LSB-first, even parity, stop.
// Delivers each word on a valid/ready holding register.
module serial_frame_receiver #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         SI,
  input  logic         bit_en,
  input  logic         rd_ready,
  output logic [N-1:0] Q,
  output logic         data_valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  shreg;
  logic          perr;
  logic          stop_hit;
  logic          load;
  logic          fe_nx;
  logic          ov_nx;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and frame resolution
  always_comb begin
    state_nx = state;
    stop_hit = 1'b0;
    if (bit_en) begin
      unique case (state)
        IDLE:   if (!SI) state_nx = DATA;
        DATA:   if (cnt == CW'(N - 1)) state_nx = PARITY;
        PARITY: state_nx = STOP;
        STOP: begin
          state_nx = IDLE;
          stop_hit = 1'b1;
        end
      endcase
    end
    load  = stop_hit && SI && (!data_valid || rd_ready);
    fe_nx = stop_hit && !SI;
    ov_nx = stop_hit && SI && data_valid && !rd_ready;
  end

  // Bit counter, shift register and parity capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else if (bit_en) begin
      unique case (state)
        IDLE: if (!SI) cnt <= '0;
        DATA: begin
          shreg <= {SI, shreg[N-1:1]};
          cnt   <= cnt + CW'(1);
        end
        PARITY: perr <= (^shreg) ^ SI;
        STOP: ;
      endcase
    end
  end

  // Holding register, handshake and error pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q          <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= fe_nx;
      overrun   <= ov_nx;
      if (load) begin
        Q          <= shreg;
        parity_err <= perr;
        data_valid <= 1'b1;
      end else if (data_valid && rd_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: directed frames plus random traffic,
// compared every cycle against a frame-level reference model.
module tb_serial_frame_receiver;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         SI = 1'b1;
  logic         bit_en = 1'b0;
  logic         rd_ready = 1'b0;
  logic [N-1:0] Q;
  logic         data_valid;
  logic         parity_err;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  bit rand_rd = 1'b0;

  serial_frame_receiver #(.N(N)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .SI(SI),
    .bit_en(bit_en),
    .rd_ready(rd_ready),
    .Q(Q),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: position within frame, collected bits, outputs
  int           pos = -1;
  bit [N-1:0]   bits = '0;
  bit           pbit = 1'b0;
  logic [N-1:0] mq = '0;
  logic         mv = 1'b0;
  logic         mpe = 1'b0;
  logic         mfe = 1'b0;
  logic         mov = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    bit ld;
    if (!reset_n) begin
      pos = -1; bits = '0; pbit = 1'b0;
      mq = '0; mv = 1'b0; mpe = 1'b0; mfe = 1'b0; mov = 1'b0;
    end else begin
      ld = 1'b0; mfe = 1'b0; mov = 1'b0;
      if (bit_en) begin
        if (pos < 0) begin
          if (!SI) pos = 0;
        end else if (pos < N) begin
          bits[pos] = SI; pos++;
        end else if (pos == N) begin
          pbit = SI; pos++;
        end else begin
          pos = -1;
          if (!SI) mfe = 1'b1;
          else if (!mv || rd_ready) ld = 1'b1;
          else mov = 1'b1;
        end
      end
      if (ld) begin
        mq = bits;
        mpe = (($countones(bits) + int'(pbit)) % 2) != 0;
        mv = 1'b1;
      end else if (mv && rd_ready) begin
        mv = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q", int'(Q), int'(mq));
      chk("valid", int'(data_valid), int'(mv));
      if (mv) chk("perr", int'(parity_err), int'(mpe));
      chk("ferr", int'(frame_err), int'(mfe));
      chk("ovr", int'(overrun), int'(mov));
      chk("busy", int'(busy), int'(pos >= 0));
    end
  end

  task automatic step(input bit en, input bit si);
    @(posedge clk);
    #2;
    bit_en = en;
    SI = si;
    if (rand_rd) rd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic put_bit(input bit b, input int gap);
    repeat (gap - 1) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, b);
  endtask

  task automatic send(input logic [N-1:0] w, input bit flip,
                      input bit stopb, input int gap, input bit rd_last);
    put_bit(1'b0, gap);
    for (int i = 0; i < N; i++) put_bit(w[i], gap);
    put_bit((^w) ^ flip, gap);
    put_bit(stopb, gap);
    if (rd_last) rd_ready = 1'b1;
    step(1'b0, 1'b1);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    step(1'b0, 1'b1);
    chk("rst_q", int'(Q), 0);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    step(1'b0, 1'b1);

    rd_ready = 1'b0;
    send(8'hA5, 1'b0, 1'b1, 1, 1'b0);
    chk("a5_q", int'(Q), 'hA5);
    chk("a5_valid", int'(data_valid), 1);
    chk("a5_perr", int'(parity_err), 0);
    chk("a5_busy", int'(busy), 0);
    rd_ready = 1'b1;
    step(1'b0, 1'b1);
    rd_ready = 1'b0;
    chk("a5_read", int'(data_valid), 0);

    send(8'h3C, 1'b1, 1'b1, 1, 1'b0);
    chk("3c_q", int'(Q), 'h3C);
    chk("3c_perr", int'(parity_err), 1);
    rd_ready = 1'b1;
    step(1'b0, 1'b1);
    rd_ready = 1'b0;

    send(8'h5A, 1'b0, 1'b0, 1, 1'b0);
    chk("5a_ferr", int'(frame_err), 1);
    chk("5a_valid", int'(data_valid), 0);
    chk("5a_q", int'(Q), 'h3C);
    step(1'b0, 1'b1);
    chk("5a_ferr_end", int'(frame_err), 0);

    send(8'h11, 1'b0, 1'b1, 1, 1'b0);
    chk("11_q", int'(Q), 'h11);
    send(8'h22, 1'b0, 1'b1, 1, 1'b0);
    chk("ovr_pulse", int'(overrun), 1);
    chk("ovr_q", int'(Q), 'h11);
    step(1'b0, 1'b1);
    chk("ovr_end", int'(overrun), 0);
    rd_ready = 1'b1;
    step(1'b0, 1'b1);
    rd_ready = 1'b0;
    send(8'h11, 1'b0, 1'b1, 1, 1'b0);
    send(8'h22, 1'b0, 1'b1, 1, 1'b1);
    chk("22_q", int'(Q), 'h22);
    chk("22_valid", int'(data_valid), 1);
    chk("22_novr", int'(overrun), 0);
    step(1'b0, 1'b1);
    rd_ready = 1'b0;

    send(8'hFF, 1'b0, 1'b1, 4, 1'b1);
    chk("ff_q", int'(Q), 'hFF);
    chk("ff_perr", int'(parity_err), 0);
    step(1'b0, 1'b1);
    rd_ready = 1'b0;

    put_bit(1'b0, 1);
    put_bit(1'b1, 1);
    put_bit(1'b0, 1);
    put_bit(1'b0, 1);
    put_bit(1'b0, 1);
    step(1'b0, 1'b1);
    reset_n = 1'b0;
    step(1'b0, 1'b1);
    chk("mid_q", int'(Q), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_valid", int'(data_valid), 0);
    reset_n = 1'b1;
    step(1'b0, 1'b1);
    send(8'h42, 1'b0, 1'b1, 1, 1'b0);
    chk("42_q", int'(Q), 'h42);
    chk("42_perr", int'(parity_err), 0);

    rand_rd = 1'b1;
    for (int f = 0; f < 300; f++) begin
      send(N'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) != 0, $urandom_range(1, 3), 1'b0);
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b1);
    end
    rand_rd = 1'b0;
    step(1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
